jt053247_draw: RTL and testbench

JT053247_DRAW -- requirements
Module: jt053247_draw

---
 rtl/jt053247_draw_if.sv | 40 ++++
 rtl/jt053247_draw.sv | 162 ++++++++++++++++
 tb/tb_jt053247_draw.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jt053247_draw_if.sv
`default_nettype none
// ============================================================================
//  Module      : jt053247_draw_if
//  Description : Bundle of draw-request, sprite-ROM and line-buffer signals
//                between the sprite scanner side and the tile drawer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface jt053247_draw_if;
    logic        dr_start;
    logic        dr_busy;
    logic [15:0] code;
    logic [9:0]  attr;
    logic        hflip;
    logic [8:0]  hpos;
    logic [3:0]  ysub;
    logic [11:0] hzoom;
    logic        hz_keep;
    logic [20:0] rom_addr;
    logic        rom_cs;
    logic        rom_ok;
    logic [31:0] rom_data;
    logic [8:0]  buf_addr;
    logic [13:0] buf_din;
    logic        buf_we;

    // Scanner / ROM / line-buffer side: issues requests, answers ROM reads
    modport master (
        output dr_start, code, attr, hflip, hpos, ysub, hzoom, hz_keep,
        output rom_ok, rom_data,
        input  dr_busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we
    );

    // Tile drawer side
    modport slave (
        input  dr_start, code, attr, hflip, hpos, ysub, hzoom, hz_keep,
        input  rom_ok, rom_data,
        output dr_busy, rom_addr, rom_cs, buf_addr, buf_din, buf_we
    );
endinterface
`default_nettype wire

// File: rtl/jt053247_draw.sv
`default_nettype none
// ============================================================================
//  Module      : jt053247_draw
//  Description : Draws one 16-pixel sprite tile row into a line buffer with
//                horizontal zoom. Two 32-bit ROM words are fetched, then one
//                output pixel is produced per clock from a fractional source
//                accumulator. Accumulator and position carry over to the next
//                tile of the same sprite when hz_keep is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module jt053247_draw #(
    parameter logic [11:0] HZ_ONE = 12'h040,
    parameter int          MAXPXL = 256
) (
    input wire          clk,
    input wire          rst,
    jt053247_draw_if.slave bus
);

    localparam int              c_CW       = $clog2(MAXPXL + 1);
    // Accumulator value reached after 16 source pixels at 1:1 scale
    localparam logic [15:0]     c_TILE_END = {HZ_ONE, 4'b0000};
    localparam logic [c_CW-1:0] c_MAXCNT   = c_CW'(MAXPXL);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2,
        DRAW   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     code_q, code_d;
    logic [9:0]      attr_q, attr_d;
    logic            hflip_q, hflip_d;
    logic [3:0]      ysub_q, ysub_d;
    logic [11:0]     step_q, step_d;
    logic [8:0]      pos_q, pos_d;
    logic [15:0]     acc_q, acc_d;
    logic [31:0]     word0_q, word0_d;
    logic [31:0]     word1_q, word1_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic            carry_ok_q, carry_ok_d;

    logic            w_half;
    logic [3:0]      w_src;
    logic [31:0]     w_word;
    logic [3:0]      w_pixel;
    logic [15:0]     w_acc_sum;
    logic [c_CW-1:0] w_cnt_inc;
    logic            w_tile_done;

    // With hflip the second half is fetched first; the half index is also
    // the address LSB and selects which word register receives the data.
    assign w_half      = (state_q == FETCH1) ^ hflip_q;
    assign w_src       = hflip_q ? ~acc_q[9:6] : acc_q[9:6];
    assign w_word      = w_src[3] ? word1_q : word0_q;
    assign w_pixel     = w_word[{~w_src[2:0], 2'b00} +: 4];
    assign w_acc_sum   = acc_q + {4'd0, step_q};
    assign w_cnt_inc   = cnt_q + c_CW'(1);
    // A carried accumulator can already be past the tile end on entry
    assign w_tile_done = (acc_q >= c_TILE_END);

    assign bus.dr_busy  = (state_q != IDLE);
    assign bus.rom_cs   = (state_q == FETCH0) || (state_q == FETCH1);
    assign bus.rom_addr = {code_q, ysub_q, w_half};
    assign bus.buf_addr = pos_q;
    assign bus.buf_din  = {attr_q, w_pixel};
    assign bus.buf_we   = (state_q == DRAW) && !w_tile_done && (w_pixel != 4'd0);

    // Next-state logic: request latch, two ROM fetches, then zoomed draw
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        attr_d     = attr_q;
        hflip_d    = hflip_q;
        ysub_d     = ysub_q;
        step_d     = step_q;
        pos_d      = pos_q;
        acc_d      = acc_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        cnt_d      = cnt_q;
        carry_ok_d = carry_ok_q;
        case (state_q)
            IDLE: begin
                if (bus.dr_start) begin
                    code_d     = bus.code;
                    attr_d     = bus.attr;
                    hflip_d    = bus.hflip;
                    ysub_d     = bus.ysub;
                    step_d     = (bus.hzoom == 12'd0) ? 12'd1 : bus.hzoom;
                    cnt_d      = '0;
                    carry_ok_d = 1'b1;
                    if (bus.hz_keep && carry_ok_q) begin
                        acc_d = w_tile_done ? (acc_q - c_TILE_END) : 16'd0;
                    end else begin
                        acc_d = 16'd0;
                        pos_d = bus.hpos;
                    end
                    state_d = FETCH0;
                end
            end
            FETCH0, FETCH1: begin
                if (bus.rom_ok) begin
                    if (w_half) begin
                        word1_d = bus.rom_data;
                    end else begin
                        word0_d = bus.rom_data;
                    end
                    state_d = (state_q == FETCH0) ? FETCH1 : DRAW;
                end
            end
            DRAW: begin
                if (w_tile_done) begin
                    state_d = IDLE;
                end else begin
                    acc_d = w_acc_sum;
                    pos_d = pos_q + 9'd1;
                    cnt_d = w_cnt_inc;
                    if ((w_acc_sum >= c_TILE_END) || (w_cnt_inc == c_MAXCNT)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything including carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            attr_q     <= '0;
            hflip_q    <= 1'b0;
            ysub_q     <= '0;
            step_q     <= '0;
            pos_q      <= '0;
            acc_q      <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
            cnt_q      <= '0;
            carry_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            attr_q     <= attr_d;
            hflip_q    <= hflip_d;
            ysub_q     <= ysub_d;
            step_q     <= step_d;
            pos_q      <= pos_d;
            acc_q      <= acc_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            cnt_q      <= cnt_d;
            carry_ok_q <= carry_ok_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt053247_draw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jt053247_draw
//  Description : Self-checking bench for jt053247_draw: vector table,
//                hand-written reset/stall sequences and random tiles checked
//                against a behavioural tile model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jt053247_draw;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt053247_draw_if bus();

    jt053247_draw dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0]  a;
        logic [13:0] d;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0] code;
        logic [3:0]  ysub;
        logic        hflip;
        logic [8:0]  hpos;
        logic [9:0]  attr;
        logic [11:0] hzoom;
        logic        keep;
        logic [31:0] w0;
        logic [31:0] w1;
        int          st0;
        int          st1;
        bit          poke;
        int          exp_nw;
        int          exp_last;
    } vec_t;
    vec_t vecs[10];

    // model carry state: final accumulator / position of the previous tile
    int m_acc = 0;
    int m_pos = 0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] nib(input logic [31:0] w0, input logic [31:0] w1, input int idx);
        logic [31:0] w;
        int p;
        w = (idx < 8) ? w0 : w1;
        p = idx % 8;
        return 4'((w >> (28 - 4 * p)) & 32'hF);
    endfunction

    // Behavioural tile: walk the source in fixed-point steps of hzoom/64
    task automatic model_tile(input logic hflip, input logic [8:0] hpos, input logic [9:0] attr,
                              input logic [11:0] hzoom, input logic keep,
                              input logic [31:0] w0, input logic [31:0] w1, output int npix);
        int acc, pos, step, s, idx;
        logic [3:0] pix;
        wr_t e;
        if (keep && m_valid) begin
            acc = (m_acc >= 1024) ? m_acc - 1024 : 0;
            pos = m_pos;
        end else begin
            acc = 0;
            pos = int'(hpos);
        end
        m_valid = 1'b1;
        step = (hzoom == 12'd0) ? 1 : int'(hzoom);
        npix = 0;
        while (acc < 1024 && npix < 256) begin
            s = (acc / 64) % 16;
            idx = hflip ? 15 - s : s;
            pix = nib(w0, w1, idx);
            if (pix != 4'd0) begin
                e.a = 9'(pos);
                e.d = {attr, pix};
                exp_q.push_back(e);
            end
            acc += step;
            pos = (pos + 1) % 512;
            npix++;
        end
        m_acc = acc;
        m_pos = pos;
    endtask

    task automatic run_tile(input logic [15:0] code, input logic [3:0] ysub, input logic hflip,
                            input logic [8:0] hpos, input logic [9:0] attr, input logic [11:0] hzoom,
                            input logic keep, input logic [31:0] w0, input logic [31:0] w1,
                            input int st0, input int st1, input bit poke,
                            output int nw, output int last_a);
        int npix, busy, cscyc, fetch, waitc, cyc;
        wr_t e;
        model_tile(hflip, hpos, attr, hzoom, keep, w0, w1, npix);
        nw = 0; last_a = -1; busy = 0; cscyc = 0; fetch = 0; waitc = 0; cyc = 0;
        @(negedge clk);
        bus.code = code; bus.ysub = ysub; bus.hflip = hflip; bus.hpos = hpos;
        bus.attr = attr; bus.hzoom = hzoom; bus.hz_keep = keep;
        bus.dr_start = 1'b1; bus.rom_ok = 1'b0;
        @(negedge clk);
        bus.dr_start = 1'b0;
        // scramble request inputs: the drawer must have latched them
        bus.code = 16'($urandom); bus.ysub = 4'($urandom); bus.hflip = 1'($urandom);
        bus.hpos = 9'($urandom); bus.attr = 10'($urandom); bus.hzoom = 12'($urandom);
        bus.hz_keep = 1'($urandom);
        chk("busy_after_start", 32'(bus.dr_busy), 32'd1);
        while (bus.dr_busy === 1'b1 && cyc < 3000) begin
            cyc++; busy++;
            bus.dr_start = 1'b0;
            if (bus.rom_cs === 1'b1) begin
                cscyc++;
                chk("rom_addr", 32'(bus.rom_addr), 32'({code, ysub, (fetch == 0) ? hflip : ~hflip}));
                bus.rom_data = bus.rom_addr[0] ? w1 : w0;
                if (waitc >= ((fetch == 0) ? st0 : st1)) begin
                    bus.rom_ok = 1'b1; fetch++; waitc = 0;
                end else begin
                    bus.rom_ok = 1'b0;
                    if (poke && fetch == 1 && waitc == st1 / 2) bus.dr_start = 1'b1;
                    waitc++;
                end
            end else begin
                bus.rom_ok = 1'b0;
            end
            if (bus.buf_we === 1'b1) begin
                nw++;
                last_a = int'(bus.buf_addr);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_write: got addr %h din %h expected no write", bus.buf_addr, bus.buf_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("buf_addr", 32'(bus.buf_addr), 32'(e.a));
                    chk("buf_din", 32'(bus.buf_din), 32'(e.d));
                end
            end
            @(negedge clk);
        end
        bus.rom_ok = 1'b0; bus.dr_start = 1'b0;
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL tile_timeout: got busy after %0d cycles expected idle", cyc);
        end
        chk("missing_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("rom_cs_cycles", 32'(cscyc), 32'(2 + st0 + st1));
        chk("busy_cycles", 32'(busy), 32'(2 + st0 + st1 + ((npix > 0) ? npix : 1)));
    endtask

    // watchdog so the bench always terminates
    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    // main test sequence
    initial begin
        int nw, la;
        vecs[0] = '{16'h1234, 4'd5, 1'b0, 9'h1FC, 10'h155, 12'h040, 1'b0, 32'h01234567, 32'h89ABCDEF, 0, 0, 1'b0, 15, 32'h00B};
        vecs[1] = '{16'h1234, 4'd5, 1'b1, 9'h1FC, 10'h155, 12'h040, 1'b0, 32'h01234567, 32'h89ABCDEF, 0, 0, 1'b0, 15, 32'h00A};
        vecs[2] = '{16'hABCD, 4'd3, 1'b0, 9'h010, 10'h2AA, 12'h020, 1'b0, 32'h11111111, 32'h22222222, 0, 10, 1'b1, 32, 32'h02F};
        vecs[3] = '{16'h0001, 4'hF, 1'b1, 9'h000, 10'h001, 12'h080, 1'b0, 32'h12345678, 32'h9ABCDEF1, 2, 1, 1'b0, 8, 32'h007};
        vecs[4] = '{16'h4321, 4'd0, 1'b0, 9'h000, 10'h3FF, 12'h030, 1'b0, 32'h11111111, 32'h11111111, 0, 0, 1'b0, 22, 32'h015};
        vecs[5] = '{16'h4321, 4'd1, 1'b0, 9'h100, 10'h3FF, 12'h030, 1'b1, 32'h11111111, 32'h11111111, 1, 0, 1'b0, 21, 32'h02A};
        vecs[6] = '{16'h0042, 4'd2, 1'b0, 9'h000, 10'h100, 12'h000, 1'b0, 32'h77777777, 32'h77777777, 0, 0, 1'b0, 256, 32'h0FF};
        vecs[7] = '{16'h0042, 4'd3, 1'b0, 9'h1F0, 10'h100, 12'h800, 1'b1, 32'h77777777, 32'h77777777, 0, 0, 1'b0, 1, 32'h100};
        vecs[8] = '{16'h0042, 4'd4, 1'b0, 9'h000, 10'h100, 12'h040, 1'b1, 32'h77777777, 32'h77777777, 0, 0, 1'b0, 0, -1};
        vecs[9] = '{16'h0042, 4'd5, 1'b1, 9'h000, 10'h100, 12'h040, 1'b1, 32'h77777777, 32'h77777777, 0, 0, 1'b0, 16, 32'h110};

        bus.dr_start = 1'b0; bus.code = '0; bus.attr = '0; bus.hflip = 1'b0; bus.hpos = '0;
        bus.ysub = '0; bus.hzoom = '0; bus.hz_keep = 1'b0; bus.rom_ok = 1'b0; bus.rom_data = '0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.dr_busy), 32'd0);
        chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("rst_buf_we", 32'(bus.buf_we), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_buf_addr", 32'(bus.buf_addr), 32'd0);
        chk("rst_buf_din", 32'(bus.buf_din), 32'd0);
        rst = 1'b0;
        m_valid = 1'b0;

        // vector table
        for (int i = 0; i < 10; i++) begin
            run_tile(vecs[i].code, vecs[i].ysub, vecs[i].hflip, vecs[i].hpos, vecs[i].attr,
                     vecs[i].hzoom, vecs[i].keep, vecs[i].w0, vecs[i].w1,
                     vecs[i].st0, vecs[i].st1, vecs[i].poke, nw, la);
            chk($sformatf("vec%0d_nwrites", i), 32'(nw), 32'(vecs[i].exp_nw));
            if (vecs[i].exp_last >= 0)
                chk($sformatf("vec%0d_last_addr", i), 32'(la), 32'(vecs[i].exp_last));
        end

        // reset in the third draw cycle aborts immediately
        @(negedge clk);
        bus.code = 16'h5555; bus.ysub = 4'd7; bus.hflip = 1'b0; bus.hpos = 9'h080;
        bus.attr = 10'h0F0; bus.hzoom = 12'h040; bus.hz_keep = 1'b0;
        bus.dr_start = 1'b1; bus.rom_ok = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus.dr_start = 1'b0;
            bus.rom_data = bus.rom_addr[0] ? 32'h33333333 : 32'h11111111;
        end
        @(negedge clk);
        chk("draw3_we_before_rst", 32'(bus.buf_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_draw_we", 32'(bus.buf_we), 32'd0);
        chk("rst_mid_draw_busy", 32'(bus.dr_busy), 32'd0);
        chk("rst_mid_draw_cs", 32'(bus.rom_cs), 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.rom_ok = 1'b0;
        m_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({bus.dr_busy, bus.buf_we}), 32'd0);
        end
        // first request after reset ignores hz_keep
        run_tile(16'h0777, 4'd9, 1'b0, 9'h040, 10'h0AA, 12'h040, 1'b1,
                 32'h12345678, 32'h9ABCDEF1, 0, 0, 1'b0, nw, la);
        chk("after_rst_nwrites", 32'(nw), 32'd16);
        chk("after_rst_last_addr", 32'(la), 32'h04F);

        // random tiles against the model
        for (int i = 0; i < 40; i++) begin
            logic [11:0] hz;
            hz = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 160));
            run_tile(16'($urandom), 4'($urandom), 1'($urandom), 9'($urandom), 10'($urandom), hz,
                     1'($urandom), $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom), nw, la);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
